// File: rtl/slp_bool_train_unit.sv
// slp_bool_train_unit
//   Sequential weight-update engine for a boolean single-layer perceptron.
//   Holds N_IN signed weights, accepts one training sample per handshake and
//   walks the weights LANES at a time, applying a saturating +/-STEP update
//   per weight (direction = XNOR(input bit, error bit)). A one-cycle done
//   pulse marks the end of each sample. Weights are read combinationally.
//
// Optional feature macro: SLP_TRAIN_BIAS_EN
//   When defined, adds a bias weight (implicit input 1) updated in the DONE
//   cycle and exposed on bias_weight.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_       in   asynchronous active-low reset
//   clr          in   clear all weights (IDLE only)
//   train_valid  in   sample present
//   train_ready  out  engine can accept a sample
//   train_in     in   [N_IN] boolean input vector
//   train_err    in   error/train bit
//   done         out  one-cycle pulse at update completion
//   busy         out  high while not IDLE
//   rd_idx       in   [IDX_W] weight read index
//   rd_weight    out  [W_PREC] weight[rd_idx], 0 when out of range
//   bias_weight  out  [W_PREC] bias weight (SLP_TRAIN_BIAS_EN only)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a sample; clr honoured here
// S_UPDATE | updating weight group grp (LANES weights per cycle)
// S_DONE   | done pulse; bias update when enabled

module slp_bool_train_unit #(
  parameter int N_IN   = 16,
  parameter int LANES  = 4,
  parameter int W_PREC = 8,
  parameter int STEP   = 1,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              clr,
  input  logic              train_valid,
  output logic              train_ready,
  input  logic [N_IN-1:0]   train_in,
  input  logic              train_err,
  output logic              done,
  output logic              busy,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [W_PREC-1:0] rd_weight
`ifdef SLP_TRAIN_BIAS_EN
  ,
  output logic [W_PREC-1:0] bias_weight
`endif
);

  localparam int K     = (N_IN + LANES - 1) / LANES;
  localparam int GRP_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(K - 1);

  // Update arithmetic is one bit wider than the weight so +/-STEP never wraps
  // before the clamp.
  localparam logic signed [W_PREC:0] STEP_X = (W_PREC+1)'(STEP);
  localparam logic signed [W_PREC:0] W_MAX  = (W_PREC+1)'((2 ** (W_PREC-1)) - 1);
  localparam logic signed [W_PREC:0] W_MIN  = (W_PREC+1)'(-(2 ** (W_PREC-1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [GRP_W-1:0]   grp;
  logic [N_IN-1:0]    in_q;
  logic               err_q;
  logic [W_PREC-1:0]  weights [N_IN];
  logic               accept;

  function automatic logic [W_PREC-1:0] sat_step(input logic [W_PREC-1:0] w,
                                                 input logic up);
    logic signed [W_PREC:0] ext;
    logic signed [W_PREC:0] sum;
    ext = $signed({w[W_PREC-1], w});
    sum = up ? (ext + STEP_X) : (ext - STEP_X);
    if (sum > W_MAX)
      sum = W_MAX;
    else if (sum < W_MIN)
      sum = W_MIN;
    return sum[W_PREC-1:0];
  endfunction

  assign accept = train_valid && train_ready;

  always_comb begin
    state_nxt   = state;
    busy        = (state != S_IDLE);
    train_ready = (state == S_IDLE) && !clr;
    done        = (state == S_DONE);
    case (state)
      S_IDLE:   if (accept) state_nxt = S_UPDATE;
      S_UPDATE: if (grp == GRP_LAST) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
      grp   <= '0;
      in_q  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && accept) begin
        in_q  <= train_in;
        err_q <= train_err;
        grp   <= '0;
      end else if (state == S_UPDATE) begin
        grp <= grp + 1'b1;
      end
    end
  end

  // Each weight belongs to group i/LANES; lanes past N_IN in the last group
  // simply have no weight mapped to them.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < N_IN; i++) weights[i] <= '0;
    end else if (state == S_IDLE && clr) begin
      for (int i = 0; i < N_IN; i++) weights[i] <= '0;
    end else if (state == S_UPDATE) begin
      for (int i = 0; i < N_IN; i++) begin
        if (grp == GRP_W'(i / LANES))
          weights[i] <= sat_step(weights[i], in_q[i] ~^ err_q);
      end
    end
  end

  // Read table padded to the full index range so out-of-range reads return 0.
  logic [W_PREC-1:0] rd_tbl [2**IDX_W];

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_rd
    if (g < N_IN) begin : g_w
      assign rd_tbl[g] = weights[g];
    end else begin : g_z
      assign rd_tbl[g] = '0;
    end
  end

  assign rd_weight = rd_tbl[rd_idx];

`ifdef SLP_TRAIN_BIAS_EN
  logic [W_PREC-1:0] bias_q;

  // Implicit input 1, so the update direction is the error bit itself.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      bias_q <= '0;
    else if (state == S_IDLE && clr)
      bias_q <= '0;
    else if (state == S_DONE)
      bias_q <= sat_step(bias_q, err_q);
  end

  assign bias_weight = bias_q;
`endif

endmodule

// File: doc/slp_bool_train_unit.md
Name: slp_bool_train_unit

Overview:
- Multi-input, sequential weight-update engine for the boolean single-layer perceptron.
- Holds N_IN signed weights in registers and accepts one training sample per handshake (input vector plus train/error bit).
- Updates LANES weights per cycle with a programmable saturating step, then signals completion.
- Sits between the sample sequencer and the SLP inference datapath, which reads weights through a combinational read port.

Parameters:
- N_IN, 16: number of boolean inputs / weights (>=1).
- LANES, 4: weights updated per cycle (1..N_IN).
- W_PREC, 8: weight width, two's-complement signed (>=2).
- STEP, 1: update magnitude per sample (1..2^(W_PREC-1)-1).
- IDX_W, $clog2(N_IN) (min 1): read-index width, derived.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_  in  1  asynchronous active-low reset.
- clr  in  1  clear all weights to 0; honoured only in IDLE.
- train_valid  in  1  sample present.
- train_ready  out  1  engine can accept a sample.
- train_in  in  N_IN  boolean input vector; bit i drives weight i.
- train_err  in  1  error/train bit.
- done  out  1  one-cycle pulse when a sample's update completes.
- busy  out  1  high while not IDLE.
- rd_idx  in  IDX_W  weight read index.
- rd_weight  out  W_PREC  weight[rd_idx], combinational; 0 if rd_idx>=N_IN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: all weights 0, state IDLE, group counter 0, done=0, busy=0, train_ready=1.
- State IDLE: train_ready = !clr.
  - clr=1: all weights become 0 next edge; train_valid ignored that cycle.
  - Else train_valid&&train_ready: capture train_in/train_err into internal registers, group counter=0, go UPDATE.
- State UPDATE: lasts K=ceil(N_IN/LANES) cycles. In cycle g, lanes j=0..LANES-1 update weight i=g*LANES+j. Lanes with i>=N_IN do nothing (last partial group). Counter increments; after g=K-1, go DONE.
- State DONE: done=1 for exactly one cycle, busy=1; next IDLE.
- Timing: accept edge at cycle t; done high in cycle t+K+1; next accept earliest at cycle t+K+2.
- busy = (state!=IDLE); train_ready=0 whenever busy.
- Update rule per weight: p = XNOR(in_i, err).
  - p=1: w += STEP.
  - p=0: w -= STEP.
  - Arithmetic is in W_PREC+1 bits signed, then saturated to [-2^(W_PREC-1), 2^(W_PREC-1)-1].
- Saturation is true signed saturation: 0 may decrement to negative. Weights at MAX with p=1, or at MIN with p=0, are unchanged.
- Captured inputs are used throughout UPDATE; train_in and train_err changes after acceptance have no effect.
- clr, train_valid and rd_idx are don't-care effects while busy: clr is ignored, not queued.
- rd_weight reflects register contents. During UPDATE it shows the mix of updated and not-yet-updated weights; the consumer reads only when !busy.
- Reset asserted mid-UPDATE: immediate return to the reset state and all weights 0; no done pulse.

Optional Feature:
- Macro: SLP_TRAIN_BIAS_EN.
- Defined:
  - Adds a bias weight with implicit input 1 (p = XNOR(1, err) = err).
  - Bias is updated in the DONE cycle with the same saturation rule; cleared by clr and reset.
  - Extra port bias_weight out W_PREC; reset value 0.
- Undefined: no bias register and no bias_weight port; behaviour as above.

Test Plan:
- Defaults: reset, accept train_in=16'hFFFF, err=1 -> done exactly 5 cycles after the accept edge; all 16 weights read 1; train_ready low for cycles t+1..t+5.
- Saturation: W_PREC=4, apply in=1/err=1 nine times -> weight 0 stops at 7 (4'h7); then in=1/err=0 seventeen times -> weight stops at -8 (4'h8), never wraps.
- Partial group: N_IN=6, LANES=4, STEP=2, train_in=6'b101010, err=0 -> K=2, done at t+3; odd-index weights = -2, even-index = +2; rd_idx=7 returns 0.
- Clear: after weights nonzero, clr=1 with train_valid=1 in IDLE -> train_ready=0 that cycle, sample not accepted, all weights 0 next cycle. clr while busy -> weights unaffected.
- Reset mid-operation: deassert reset_ during the second UPDATE cycle -> immediately busy=0, train_ready=1, all weights 0; no done pulse follows.
- With SLP_TRAIN_BIAS_EN defined: err=1 three times, then err=0 once -> bias_weight=2; clr -> 0.
